// File: rtl/median_win_pkg.sv
// Shared types and elaboration helpers for the median window store.
// Latency: n/a (package only).
// Backpressure: n/a.
package median_win_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Ceiling log2, evaluated at elaboration for port and counter widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // A window must never reach the addresses the writer can touch while the
  // window is being read out; the margin covers the read pipeline depth.
  function automatic bit win_max_ok(input int win_max, input int aw);
    return win_max <= ((1 << aw) / 2 - 4);
  endfunction

endpackage

// File: rtl/median_win_sdp.sv
// Generic inferred simple dual-port RAM, read-first, optional output register.
// Latency: read data 1 + OUTPUT_REG cycles after raddr/re.
// Backpressure: none; one write and one read per cycle.
//   clk          : single clock, rising edge
//   we/waddr/wdata : write port
//   re/raddr     : read port request
//   rdata        : read data (not reset)
module median_win_sdp #(
  parameter int DW         = 16,
  parameter int AW         = 7,
  parameter int OUTPUT_REG = 0
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] q;

  // Non-blocking read of mem gives the pre-write value on an address clash.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end

  generate
    if (OUTPUT_REG != 0) begin : g_oreg
      logic [DW-1:0] q2;
      always_ff @(posedge clk) q2 <= q;
      assign rdata = q2;
    end else begin : g_noreg
      assign rdata = q;
    end
  endgenerate

endmodule

// File: rtl/median_win_ram.sv
// Per-channel circular sample store; streams the newest N samples of one channel.
// Latency: first beat RL+1 cycles after acceptance (RL = 1 + OUTPUT_REG), then one beat per cycle.
// Backpressure: writes never stall; win_ready low while a window is in flight, no output backpressure.
//   in_valid/in_ch/in_data     : sample write, one per cycle
//   win_req/win_ch/win_len     : window request, accepted on win_req && win_ready
//   out_valid/out_data/out_last: window beats, newest first
//   out_err                    : one-cycle pulse when the effective window length is 0
module median_win_ram
  import median_win_pkg::*;
#(
  parameter int DW         = 16,
  parameter int AW         = 6,
  parameter int CH         = 2,
  parameter int WIN_MAX    = 9,
  parameter int OUTPUT_REG = 0,
  localparam int CW        = (clog2(CH) < 1) ? 1 : clog2(CH),
  localparam int LW        = clog2(WIN_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [CW-1:0] in_ch,
  input  logic [DW-1:0] in_data,
  input  logic          win_req,
  input  logic [CW-1:0] win_ch,
  input  logic [LW-1:0] win_len,
  output logic          win_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          out_err
);

  localparam int DEPTH = 1 << AW;
  localparam int RL    = 1 + OUTPUT_REG;
  localparam int RA    = CW + AW;
  localparam logic [CW:0] CH_L = (CW + 1)'(CH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] WMAX = (AW + 1)'(WIN_MAX);

  generate
    if (!win_max_ok(WIN_MAX, AW)) begin : g_cfg_bad
      $error("median_win_ram: WIN_MAX too large for DEPTH");
    end
  endgenerate

  // ---------------- write side ----------------
  logic [AW-1:0] wr_ptr [CH];
  logic [AW:0]   fill   [CH];
  logic          wr_en;
  logic [RA-1:0] wr_addr;

  assign wr_en   = in_valid && ({1'b0, in_ch} < CH_L);
  assign wr_addr = {in_ch, wr_ptr[in_ch]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        wr_ptr[i] <= '0;
        fill[i]   <= '0;
      end
    end else if (wr_en) begin
      wr_ptr[in_ch] <= wr_ptr[in_ch] + AW'(1);
      if (fill[in_ch] != FULL) fill[in_ch] <= fill[in_ch] + (AW + 1)'(1);
    end
  end

  // ---------------- request snapshot ----------------
  // Sampled from the registered pointer/fill, so a same-cycle write to the
  // requested channel is excluded from the window.
  logic          ch_ok;
  logic [AW-1:0] snap_ptr;
  logic [AW:0]   snap_fill;
  logic [AW:0]   n_full;
  logic [LW-1:0] n_eff;

  always_comb begin
    ch_ok     = ({1'b0, win_ch} < CH_L);
    snap_ptr  = '0;
    snap_fill = '0;
    if (ch_ok) begin
      snap_ptr  = wr_ptr[win_ch];
      snap_fill = fill[win_ch];
    end
    n_full = (AW + 1)'(win_len);
    if (snap_fill < n_full) n_full = snap_fill;
    if (WMAX < n_full)      n_full = WMAX;
    n_eff = LW'(n_full);
  end

  // ---------------- read FSM ----------------
  state_t        state;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] rd_ch;
  logic [LW-1:0] rem;
  logic          rd_en;
  logic          rd_last;
  logic [RL-1:0] vld_pipe;
  logic [RL-1:0] last_pipe;

  assign rd_en   = (state == READ);
  assign rd_last = rd_en && (rem == LW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      win_ready <= 1'b1;
      out_err   <= 1'b0;
      rd_ptr    <= '0;
      rd_ch     <= '0;
      rem       <= '0;
    end else begin
      out_err <= 1'b0;
      case (state)
        IDLE: begin
          if (win_req) begin
            if (n_eff == '0) begin
              out_err <= 1'b1;
            end else begin
              state     <= READ;
              win_ready <= 1'b0;
              rd_ptr    <= snap_ptr - AW'(1);
              rd_ch     <= win_ch;
              rem       <= n_eff;
            end
          end
        end
        READ: begin
          rd_ptr <= rd_ptr - AW'(1);
          rem    <= rem - LW'(1);
          if (rem == LW'(1)) state <= DRAIN;
        end
        DRAIN: begin
          // Leave once the final beat is on the output this cycle.
          if (last_pipe[RL-1]) begin
            state     <= IDLE;
            win_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          win_ready <= 1'b1;
        end
      endcase
    end
  end

  // valid/last travel alongside the RAM read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe[0]  <= rd_en;
      last_pipe[0] <= rd_last;
      for (int i = 1; i < RL; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  // ---------------- storage ----------------
  logic [DW-1:0] ram_q;

  median_win_sdp #(
    .DW        (DW),
    .AW        (RA),
    .OUTPUT_REG(OUTPUT_REG)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_addr),
    .wdata(in_data),
    .re   (rd_en),
    .raddr({rd_ch, rd_ptr}),
    .rdata(ram_q)
  );

  assign out_valid = vld_pipe[RL-1];
  assign out_last  = last_pipe[RL-1];
  // RAM data is not reset; gating keeps out_data at 0 outside a beat.
  assign out_data  = out_valid ? ram_q : '0;

endmodule
